// File: rtl/seq_alu.sv
// Multi-cycle ALU: ADD/SUB/SLT ripple through a CHUNK-bit adder one chunk per clock,
// logic/EQ ops finish in one cycle. Define SEQ_ALU_PRIENC_EN to enable op 1000 (PENC).
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             zero
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_NOT  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_EQ   = 4'b0111;
`ifdef SEQ_ALU_PRIENC_EN
    localparam logic [3:0] OP_PENC = 4'b1000;
`endif

    logic [1:0]       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cy_q, cy_d;

    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             chunk_ovf;
    logic [WIDTH-1:0] single_res;

    // Subtraction is a + ~b + 1: the +1 arrives as the initial running carry.
    always_comb begin
        a_chunk   = a_q[idx_q*CHUNK +: CHUNK];
        b_chunk   = b_q[idx_q*CHUNK +: CHUNK] ^ {CHUNK{op_q != OP_ADD}};
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, cy_q};
        chunk_ovf = (a_chunk[CHUNK-1] == b_chunk[CHUNK-1]) &&
                    (chunk_sum[CHUNK-1] != a_chunk[CHUNK-1]);
    end

    always_comb begin
        single_res = '0;
        case (op)
            OP_NOT:  single_res = ~a;
            OP_AND:  single_res = a & b;
            OP_OR:   single_res = a | b;
            OP_XOR:  single_res = a ^ b;
            OP_EQ:   single_res = {{(WIDTH-1){1'b0}}, a == b};
            default: begin
`ifdef SEQ_ALU_PRIENC_EN
                if (op == OP_PENC) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (a[i]) single_res = WIDTH'(i);
                    end
                end
`endif
            end
        endcase
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block infers a latch.
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        idx_d       = idx_q;
        cy_d        = cy_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    if (op == OP_ADD || op == OP_SUB || op == OP_SLT) begin
                        state_d = CALC;
                        idx_d   = '0;
                        cy_d    = (op != OP_ADD);
                    end else begin
                        result_d    = single_res;
                        zero_d      = (single_res == '0);
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end
                end
            end
            CALC: begin
                result_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                cy_d  = chunk_sum[CHUNK];
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N - 1)) begin
                    carry_d = chunk_sum[CHUNK];
                    ovf_d   = chunk_ovf;
                    if (op_q == OP_SLT) begin
                        result_d = {{(WIDTH-1){1'b0}}, chunk_sum[CHUNK-1] ^ chunk_ovf};
                    end
                    zero_d      = (result_d == '0);
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    idx_d       = '0;
                    cy_d        = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
            cy_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
            cy_q        <= cy_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
endmodule
